// File: rtl/multiplier_control.sv
// Sequencing FSM for the iterative shift-add multiplier: handshakes operands in, steps the
// datapath once per bit, holds the product. Define MULTIPLIER_EARLY_EXIT_EN for early exit.
module multiplier_control #(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    input  logic abort,
    input  logic multiplier_lsb,
    input  logic is_zero,
`ifdef MULTIPLIER_EARLY_EXIT_EN
    input  logic multiplier_rest_zero,
`endif
    output logic do_preset,
    output logic do_decrement,
    output logic load_operands,
    output logic add_en,
    output logic shift_en,
    output logic busy
);

    if (N < 2) begin : g_width_check
        $error("multiplier_control: N must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_STEP = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state_q;
    state_t state_next;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // NOTE: every output and the next state get a default first, so no path infers a latch.
    always_comb begin
        state_next    = state_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        do_preset     = 1'b0;
        do_decrement  = 1'b0;
        load_operands = 1'b0;
        add_en        = 1'b0;
        shift_en      = 1'b0;
        busy          = 1'b0;

        // Outputs are held quiet for the whole time reset is high, not just after the edge.
        if (reset) begin
            state_next = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load_operands = 1'b1;
                        do_preset     = 1'b1;
                        state_next    = S_STEP;
                    end
                end

                S_STEP: begin
                    busy = 1'b1;
                    if (abort) begin
                        state_next = S_IDLE;
`ifdef MULTIPLIER_EARLY_EXIT_EN
                    end else if (multiplier_rest_zero) begin
                        state_next = S_DONE;
`endif
                    end else begin
                        shift_en = 1'b1;
                        add_en   = multiplier_lsb;
                        if (is_zero) begin
                            state_next = S_DONE;
                        end else begin
                            do_decrement = 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    busy      = 1'b1;
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_next = S_IDLE;
                    end
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_control.sv
// Scoreboard bench for multiplier_control: models the counter and shift-add datapath around it,
// predicts product, latency and add pattern from the operands, and checks on each product handshake.
module tb_multiplier_control;

    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic abort = 1'b0;
    logic in_ready, out_valid, do_preset, do_decrement, load_operands, add_en, shift_en, busy;
    logic multiplier_lsb, is_zero;

    logic [N-1:0]   a_in = '0;
    logic [N-1:0]   b_in = '0;
    logic [2*N-1:0] mcand_q = '0;
    logic [2*N-1:0] acc_q = '0;
    logic [N-1:0]   mplier_q = '0;
    int             cnt_q = 0;
    int             cyc = 0;
    int             ready_mode = 0;   // 0: always ready, 1: random, 2: driven by a test

    int total = 0;
    int passed = 0;

    assign multiplier_lsb = mplier_q[0];
    assign is_zero        = (cnt_q == 0);

    multiplier_control #(.N(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .abort          (abort),
        .multiplier_lsb (multiplier_lsb),
        .is_zero        (is_zero),
`ifdef MULTIPLIER_EARLY_EXIT_EN
        .multiplier_rest_zero (mplier_q == '0),
`endif
        .do_preset      (do_preset),
        .do_decrement   (do_decrement),
        .load_operands  (load_operands),
        .add_en         (add_en),
        .shift_en       (shift_en),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Neighbouring blocks: down-counter and shift-add datapath, driven only by the DUT strobes.
    always @(posedge clock) begin
        if (do_preset) cnt_q <= N - 1;
        else if (do_decrement) cnt_q <= cnt_q - 1;
        if (load_operands) begin
            mcand_q  <= {{N{1'b0}}, a_in};
            mplier_q <= b_in;
            acc_q    <= '0;
        end else begin
            if (add_en) acc_q <= acc_q + mcand_q;
            if (shift_en) begin
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    typedef struct {
        int product;
        int start;
        int lat;
        int shifts;
        int pattern;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input string detail);
        total++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    function automatic int bit_length(input int v);
        int n = 0;
        for (int i = 0; i < N; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic exp_t model(input int a, input int b, input int t);
        exp_t e;
        e.product = a * b;
        e.start   = t;
        e.pattern = b;
`ifdef MULTIPLIER_EARLY_EXIT_EN
        e.shifts  = (bit_length(b) < N) ? bit_length(b) : N;
        e.lat     = (bit_length(b) + 2 < N + 1) ? bit_length(b) + 2 : N + 1;
`else
        e.shifts  = N;
        e.lat     = N + 1;
`endif
        return e;
    endfunction

    // Monitor: per-cycle strobe rules, plus scoreboard comparison whenever a product is presented.
    int         shift_cnt = 0;
    logic [N-1:0] pat = '0;
    bit         seen_valid = 1'b0;
    bit         idle_due = 1'b0;

    always @(negedge clock) begin
        if (idle_due) begin
            check("idle_after_take", in_ready, 1);
            idle_due = 1'b0;
        end
        check("strobe_exclusive",
              (load_operands && (shift_en || add_en)) || (do_preset && do_decrement), 0);
        if (load_operands) begin
            shift_cnt  = 0;
            pat        = '0;
            seen_valid = 1'b0;
        end
        if (shift_en) begin
            if (shift_cnt < N) pat[shift_cnt] = add_en;
            shift_cnt++;
        end
        if (out_valid) begin
            if (sb.size() == 0) begin
                fail_now("spurious_out_valid", "out_valid high with no operation outstanding");
            end else begin
                if (!seen_valid) begin
                    check("latency", cyc - sb[0].start, sb[0].lat);
                    check("step_count", shift_cnt, sb[0].shifts);
                    check("add_pattern", pat, sb[0].pattern);
                    seen_valid = 1'b1;
                end
                check("product", acc_q, sb[0].product);
                check("in_ready_low_in_done", in_ready, 0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    idle_due = 1'b1;
                end
            end
        end
    end

    task automatic step_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input int a, input int b, input bit ab);
        bit ok = 1'b0;
        a_in     = a[N-1:0];
        b_in     = b[N-1:0];
        in_valid = 1'b1;
        abort    = ab;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back(model(a, b, cyc));
                ok = 1'b1;
            end
            step_edge();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        if (!ok) fail_now("accept_timeout", "in_ready never seen within 100 cycles");
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && in_ready) ok = 1'b1;
            step_edge();
        end
        if (!ok) fail_now("idle_timeout", "operation did not complete within 200 cycles");
    endtask

    // Called from the first STEP cycle; aborts during STEP number k.
    task automatic abort_at(input int k);
        repeat (k - 1) step_edge();
        abort = 1'b1;
        @(negedge clock);
        check("abort_strobes_off", {load_operands, shift_en, add_en, do_decrement}, 0);
        if (sb.size() > 0) void'(sb.pop_back());
        step_edge();
        abort = 1'b0;
        @(negedge clock);
        check("idle_after_abort", in_ready, 1);
        check("no_valid_after_abort", out_valid, 0);
        step_edge();
    endtask

    task automatic reset_at(input int k);
        repeat (k - 1) step_edge();
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset_outputs",
              {in_ready, out_valid, do_preset, do_decrement, load_operands, add_en, shift_en, busy}, 0);
        if (sb.size() > 0) void'(sb.pop_back());
        step_edge();
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_mid_reset", in_ready, 1);
        check("no_valid_after_reset", out_valid, 0);
        step_edge();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        repeat (2) begin
            @(negedge clock);
            check("reset_outputs",
                  {in_ready, out_valid, do_preset, do_decrement, load_operands, add_en, shift_en, busy}, 0);
        end
        step_edge();
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", in_ready, 1);
        check("not_busy_after_reset", busy, 0);
        step_edge();

        // 5 x 3: add pattern 1,1,0,0; product 15.
        run_op(5, 3, 1'b0);
        wait_idle();

        // 15 x 15 under backpressure, with abort asserted during DONE (must be ignored).
        ready_mode = 2;
        out_ready  = 1'b0;
        run_op(15, 15, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
            else step_edge();
        end
        if (!seen) fail_now("done_timeout", "out_valid never seen for 15x15");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                step_edge();
                abort     = (i == 1);
                out_ready = (i == 3);
            end
            if (i > 0) @(negedge clock);
            check("valid_held", out_valid, 1);
            check("ready_low_held", in_ready, 0);
        end
        step_edge();
        abort      = 1'b0;
        ready_mode = 0;
        @(negedge clock);
        check("valid_dropped", out_valid, 0);
        step_edge();

        // Abort in the 2nd STEP, then a normal 2 x 7.
        run_op(15, 15, 1'b0);
        abort_at(2);
        run_op(2, 7, 1'b0);
        wait_idle();

        // Abort coinciding with the final STEP: abort wins.
        run_op(13, 11, 1'b0);
        abort_at(N);

        // Abort while IDLE is ignored: operation still accepted and completed.
        run_op(6, 9, 1'b1);
        wait_idle();

        // Reset in the 3rd STEP.
        run_op(15, 15, 1'b0);
        reset_at(3);

        // Small multipliers (early exit shortens these when enabled).
        run_op(9, 1, 1'b0);
        wait_idle();
        run_op(9, 0, 1'b0);
        wait_idle();

        // Randomized operands, gaps and backpressure.
        ready_mode = 1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) step_edge();
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
        end
        wait_idle();
        ready_mode = 0;
        step_edge();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
